// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and defaults for the register-bank arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dff_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      GAP   = 2'b10
   } arb_state_e;

   localparam int DEF_NUM_REQ  = 3;
   localparam int DEF_WIDTH    = 6;
   localparam int DEF_MAX_HOLD = 4;

   // Bits needed to index n items; never less than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the register-bank arbiter: requests, write data, clear, grant and bank outputs.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until they see their gnt bit; the bank has no stall.
interface dff_bank_arbiter_if import dff_arb_pkg::*; #(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH
);
   localparam int OW = idx_w(NUM_REQ);

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] wdata;
   logic                     clr;
   logic [NUM_REQ-1:0]       gnt;
   logic [OW-1:0]            owner;
   logic [WIDTH-1:0]         q;
   logic                     busy;

   modport master (output req, wdata, clr, input gnt, owner, q, busy);
   modport slave  (input req, wdata, clr, output gnt, owner, q, busy);

endinterface

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from start, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; any=0 when no request is set.
module rr_pick import dff_arb_pkg::*; #(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int OW      = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [OW-1:0]      start,
   output logic               any,
   output logic [OW-1:0]      winner
);

   // Walk the search order backwards so the last hit is the one closest to start.
   always_comb begin
      int idx;
      any    = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(start) + i) % NUM_REQ;
         if (req[idx]) begin
            any    = 1'b1;
            winner = OW'(idx);
         end
      end
   end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin owner of one shared register bank; the granted requester loads its wdata every cycle.
// Latency: gnt one edge after req; first bank load one edge after gnt; one GAP cycle between owners.
// Backpressure: an owner is cut after MAX_HOLD loads only while another requester waits.
module dff_bank_arbiter import dff_arb_pkg::*; #(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input logic               clk,
   input logic               reset,
   dff_bank_arbiter_if.slave bus
);

   localparam int OW = idx_w(NUM_REQ);
   localparam int HW = idx_w(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
   localparam logic [OW-1:0] LAST_IDX = OW'(NUM_REQ - 1);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [OW-1:0]      owner_q, owner_d;
   logic [OW-1:0]      rr_q, rr_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [WIDTH-1:0]   q_q, q_d;

   logic               pick_any;
   logic [OW-1:0]      pick_win;
   logic               own_req;
   logic               others;
   logic [OW-1:0]      rr_after_owner;

   // One picker serves both the IDLE and GAP arbitration paths.
   rr_pick #(.NUM_REQ(NUM_REQ), .OW(OW)) u_pick (
      .req    (bus.req),
      .start  (rr_q),
      .any    (pick_any),
      .winner (pick_win)
   );

   assign own_req        = bus.req[owner_q];
   assign others         = |(bus.req & ~gnt_q);
   assign rr_after_owner = (owner_q == LAST_IDX) ? '0 : owner_q + OW'(1);

   // Next-state, grant, hold counter and bank load; clr overrides any load in every state.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      hold_d  = hold_q;
      q_d     = q_q;
      case (state_q)
         IDLE, GAP: begin
            if (pick_any) begin
               state_d           = GRANT;
               gnt_d             = '0;
               gnt_d[pick_win]   = 1'b1;
               owner_d           = pick_win;
               hold_d            = '0;
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         end
         GRANT: begin
            if (hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
            if (!own_req) begin
               // Owner released: leave without loading.
               state_d = GAP;
               gnt_d   = '0;
               rr_d    = rr_after_owner;
            end else begin
               q_d = bus.wdata[int'(owner_q)*WIDTH +: WIDTH];
               // Hold limit only bites when someone else is waiting; this edge is the last load.
               if (hold_q == HOLD_MAX && others) begin
                  state_d = GAP;
                  gnt_d   = '0;
                  rr_d    = rr_after_owner;
               end
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
      if (bus.clr) q_d = '0;
   end

   // State and bank registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         rr_q    <= '0;
         hold_q  <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         hold_q  <= hold_d;
         q_q     <= q_d;
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.owner = owner_q;
   assign bus.q     = q_q;
   assign bus.busy  = (state_q != IDLE);

endmodule
